pipeline_hazard_ctrl: RTL

Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and stalls IF/ID.
- Flushes wrong-path instructions when a branch or jump resolves in MEM.
- Drains the pipeline on a HALT instruction.
- Keeps saturating performance counters.
- Drives per-register enable/flush controls in place of the single global enable.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/sat_counter.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and opcode constants for the pipeline sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_J       = 6'b000010;

    // A taken branch or any jump resolving in MEM redirects the fetch stream.
    function automatic logic is_redirect(input logic branch, input logic zero,
                                         input logic jump);
        return jump | (branch & zero);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Load-use stall, redirect flush and HALT drain sequencer for a
//               5-stage MIPS pipeline, with saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter logic [5:0] HALT_OPCODE  = cpu_ctrl_pkg::HALT_OPCODE,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import cpu_ctrl_pkg::*;

    localparam int            DW           = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] C_DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0] C_DRAIN_ONE  = DW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_drain_cnt;
    logic [DW-1:0] w_drain_nxt;
    logic          r_halted;

    logic          w_redirect;
    logic          w_load_use;
    logic          w_is_halt;

    logic          w_pc_en;
    logic          w_ifid_en;
    logic          w_ifid_flush;
    logic          w_idex_flush;
    logic          w_exmem_flush;
    logic          w_cyc_inc;
    logic          w_stall_inc;
    logic          w_flush_inc;

    assign w_redirect = is_redirect(mem_branch, mem_zero, mem_jump);
    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_load_use = ex_mem_read && (ex_waddr != 5'd0) &&
                        ((ex_waddr == id_rs) || (id_uses_rt && (ex_waddr == id_rt)));
    assign w_is_halt  = (id_opcode == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == HALTED);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_cyc_inc     = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        // With enable low every default above holds: outputs idle, state frozen.
        if (enable) begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = RUN;
                end

                RUN: begin
                    w_cyc_inc = 1'b1;
                    if (w_redirect) begin
                        w_pc_en       = 1'b1;
                        w_ifid_en     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_exmem_flush = 1'b1;
                        w_flush_inc   = 1'b1;
                    end else if (w_load_use) begin
                        w_idex_flush  = 1'b1;
                        w_stall_inc   = 1'b1;
                    end else if (w_is_halt) begin
                        // HALT becomes a bubble in ID/EX; the fetched slot behind it is dropped.
                        w_ifid_en     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_drain_nxt   = C_DRAIN_LOAD;
                        w_state_nxt   = DRAIN;
                    end else begin
                        w_pc_en       = 1'b1;
                        w_ifid_en     = 1'b1;
                    end
                end

                DRAIN: begin
                    w_cyc_inc = 1'b1;
                    if (w_redirect) begin
                        // An older branch resolved taken: the HALT was wrong-path.
                        w_pc_en       = 1'b1;
                        w_ifid_en     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_exmem_flush = 1'b1;
                        w_flush_inc   = 1'b1;
                        w_drain_nxt   = '0;
                        w_state_nxt   = RUN;
                    end else if (r_drain_cnt == '0) begin
                        w_state_nxt   = HALTED;
                    end else begin
                        w_drain_nxt   = r_drain_cnt - C_DRAIN_ONE;
                    end
                end

                HALTED: begin
                    w_state_nxt = HALTED;
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = w_exmem_flush;
    assign halted      = r_halted;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_cyc_inc),
        .count  (cycle_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_stall_inc),
        .count  (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_flush_inc),
        .count  (flush_cnt)
    );

endmodule
`default_nettype wire
